password_lock_controller: RTL and testbench
===========================================

PASSWORD_LOCK_CONTROLLER -- requirements
Module: password_lock_controller

Interface
REQ-001 SHALL have parameter DEFAULT_CODE, 16'h1234, code loaded at reset; digit 0 is in bits [15:12].
REQ-002 SHALL have parameter MAX_FAILS, 3, number of consecutive wrong codes that triggers lockout (range 1-3).
REQ-003 SHALL have parameter UNLOCK_CYCLES, 100000000, number of cycles unlocked stays high.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, 500000000, number of cycles lockout stays high.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port enter, input, 1, single-cycle pulse (debounced and edge-detected upstream) that accepts digit.
REQ-008 SHALL have port clear, input, 1, single-cycle pulse that discards the partial entry.
REQ-009 SHALL have port digit, input, 4, value to enter; 4'h0-4'hF are all legal.
REQ-010 SHALL have port prog, input, 1, level; when high in OPEN, enters program a new code.
REQ-011 SHALL have port unlocked, output, 1, door-open indication (drives status LEDs).
REQ-012 SHALL have port lockout, output, 1, lockout active.
REQ-013 SHALL have port entry_count, output, 3, digits entered so far (0-4).
REQ-014 SHALL have port fail_count, output, 2, consecutive failures.
REQ-015 SHALL have port display_value, output, 8, value for the seven-segment display controller.

Function
REQ-016 SHALL implement FSM states IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT; all outputs registered.
REQ-017 SHALL, on enter in IDLE/ENTRY, shift entry_reg <= {entry_reg[11:0], digit}, increment entry_count, and go to ENTRY.
REQ-018 SHALL, on the 4th enter, go to CHECK the next cycle; CHECK lasts exactly 1 cycle and ignores enter and clear.
REQ-019 SHALL, in CHECK on entry_reg == code_reg, go to OPEN, clear fail_count, load the timer with UNLOCK_CYCLES, and clear entry.
REQ-019a Timing of REQ-019: unlocked rises 2 cycles after the 4th enter.
REQ-020 SHALL, in CHECK on mismatch, increment fail_count; if the new value == MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES, else go to IDLE; entry is cleared in both cases.
REQ-021 SHALL, in OPEN, hold unlocked=1 and decrement the timer each cycle while prog=0; unlocked is high for exactly UNLOCK_CYCLES cycles, then IDLE.
REQ-022 SHALL, in OPEN with prog=1 on an enter, go to PROG and capture that digit as the first new digit; the timer is frozen in PROG.
REQ-023 SHALL, in PROG, shift digits as in REQ-017; on the 4th digit write code_reg, clear entry, and go to IDLE (unlocked drops the next cycle).
REQ-024 SHALL, on prog falling in PROG before 4 digits, discard the partial code and return to OPEN with the timer resumed.
REQ-025 SHALL, in LOCKOUT, hold lockout=1 for exactly LOCKOUT_CYCLES cycles and ignore enter/clear/prog; on expiry, clear fail_count and go to IDLE.
REQ-026 SHALL, on clear in ENTRY or PROG, reset entry_reg and entry_count and return to IDLE or OPEN respectively; clear in other states has no effect.
REQ-027 SHALL give clear priority when enter and clear are asserted in the same cycle; that digit is discarded.
REQ-028 SHALL drive display_value as follows:
- IDLE: 8'h00
- ENTRY/PROG: {1'b0, entry_count, last digit}
- OPEN: 8'h0E
- LOCKOUT: 8'hFF
REQ-029 SHALL keep fail_count unchanged by clear and by OPEN timeout; only a match or lockout expiry clears it.

Reset
REQ-030 SHALL, with rst high at a clock edge, set state to IDLE, code_reg to DEFAULT_CODE, and entry_reg, entry_count, fail_count and timer to 0.
REQ-030a Also on reset: unlocked=0, lockout=0, display_value=8'h00; rst overrides all inputs, including mid-OPEN, PROG or LOCKOUT.

Verification (bench uses UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, MAX_FAILS=3)
REQ-031 SHALL cover: enter 1,2,3,4 after reset -> unlocked=1 two cycles after the 4th enter for exactly 8 cycles, display 8'h0E, fail_count=0.
REQ-032 SHALL cover: enter 1,2,3,5 three times -> fail_count 1,2, then lockout=1 for exactly 16 cycles, display 8'hFF, enters ignored; afterwards fail_count=0 and 1,2,3,4 unlocks.
REQ-033 SHALL cover: enter 1,2, then clear and enter in the same cycle -> entry_count=0, display 8'h00; then 1,2,3,4 unlocks.
REQ-034 SHALL cover: unlock, set prog=1, enter A,B,C,D -> IDLE; 1,2,3,4 now fails, A,B,C,D unlocks.
REQ-035 SHALL cover: unlock, prog=1, enter 9,9, drop prog -> back in OPEN, code unchanged, timer resumes from its frozen value.
REQ-036 SHALL cover: assert rst during LOCKOUT and during PROG -> next cycle all outputs at reset values, code_reg=16'h1234.

Source files
------------

// File: rtl/password_lock_controller.sv
// Four-digit keypad lock with timed unlock, code programming
// and lockout after repeated wrong entries.
module password_lock_controller #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_FAILS = 3,
  parameter int UNLOCK_CYCLES = 100000000,
  parameter int LOCKOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       clear,
  input  logic [3:0] digit,
  input  logic       prog,
  output logic       unlocked,
  output logic       lockout,
  output logic [2:0] entry_count,
  output logic [1:0] fail_count,
  output logic [7:0] display_value
);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT
  } state_t;

  localparam logic [31:0] UNLOCK_T = 32'(UNLOCK_CYCLES);
  localparam logic [31:0] LOCK_T = 32'(LOCKOUT_CYCLES);
  localparam logic [1:0] FAIL_LIM = 2'(MAX_FAILS);

  state_t      state;
  logic [15:0] code_reg;
  logic [15:0] entry_reg;
  logic [31:0] timer;

  logic [15:0] entry_nxt;
  logic [2:0]  cnt_inc;
  logic [1:0]  fail_inc;
  logic [7:0]  entry_disp;

  assign entry_nxt = {entry_reg[11:0], digit};
  assign cnt_inc = entry_count + 3'd1;
  assign fail_inc = fail_count + 2'd1;
  assign entry_disp = {1'b0, cnt_inc, digit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code_reg <= DEFAULT_CODE;
      entry_reg <= '0;
      entry_count <= '0;
      fail_count <= '0;
      timer <= '0;
      unlocked <= 1'b0;
      lockout <= 1'b0;
      display_value <= 8'h00;
    end else begin
      unique case (state)
        IDLE, ENTRY: begin
          // clear wins over enter; in IDLE it just drops the digit
          if (clear) begin
            if (state == ENTRY) begin
              entry_reg <= '0;
              entry_count <= '0;
              display_value <= 8'h00;
              state <= IDLE;
            end
          end else if (enter) begin
            entry_reg <= entry_nxt;
            entry_count <= cnt_inc;
            display_value <= entry_disp;
            state <= (entry_count == 3'd3) ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          entry_reg <= '0;
          entry_count <= '0;
          if (entry_reg == code_reg) begin
            state <= OPEN;
            fail_count <= '0;
            timer <= UNLOCK_T;
            unlocked <= 1'b1;
            display_value <= 8'h0E;
          end else if (fail_inc == FAIL_LIM) begin
            state <= LOCKOUT;
            fail_count <= fail_inc;
            timer <= LOCK_T;
            lockout <= 1'b1;
            display_value <= 8'hFF;
          end else begin
            state <= IDLE;
            fail_count <= fail_inc;
            display_value <= 8'h00;
          end
        end
        OPEN: begin
          if (prog) begin
            if (enter && !clear) begin
              state <= PROG;
              entry_reg <= entry_nxt;
              entry_count <= cnt_inc;
              display_value <= entry_disp;
            end
          end else if (timer <= 32'd1) begin
            state <= IDLE;
            timer <= '0;
            unlocked <= 1'b0;
            display_value <= 8'h00;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        PROG: begin
          // timer stays frozen here; leaving early resumes OPEN
          if (clear || !prog) begin
            entry_reg <= '0;
            entry_count <= '0;
            display_value <= 8'h0E;
            state <= OPEN;
          end else if (enter) begin
            if (entry_count == 3'd3) begin
              code_reg <= entry_nxt;
              entry_reg <= '0;
              entry_count <= '0;
              timer <= '0;
              unlocked <= 1'b0;
              display_value <= 8'h00;
              state <= IDLE;
            end else begin
              entry_reg <= entry_nxt;
              entry_count <= cnt_inc;
              display_value <= entry_disp;
            end
          end
        end
        LOCKOUT: begin
          if (timer <= 32'd1) begin
            state <= IDLE;
            timer <= '0;
            lockout <= 1'b0;
            fail_count <= '0;
            display_value <= 8'h00;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_password_lock_controller.sv
// Scoreboard bench for password_lock_controller: stimulus pushes
// hand-derived per-cycle expectations, a monitor pops and compares.
module tb_password_lock_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       prog = 1'b0;
  logic       unlocked;
  logic       lockout;
  logic [2:0] entry_count;
  logic [1:0] fail_count;
  logic [7:0] display_value;

  password_lock_controller #(
    .DEFAULT_CODE(16'h1234),
    .MAX_FAILS(3),
    .UNLOCK_CYCLES(8),
    .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enter(enter),
    .clear(clear),
    .digit(digit),
    .prog(prog),
    .unlocked(unlocked),
    .lockout(lockout),
    .entry_count(entry_count),
    .fail_count(fail_count),
    .display_value(display_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       u;
    logic       l;
    logic [2:0] ec;
    logic [1:0] fc;
    logic [7:0] dv;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    vectors = 0;
  int    miscompares = 0;
  string tag = "reset";

  localparam int R_OK = 0;
  localparam int R_BAD = 1;
  localparam int R_LOCK = 2;

  task automatic step(
    input bit r, input bit e, input bit c,
    input logic [3:0] d, input bit p,
    input logic u, input logic l,
    input logic [2:0] ec, input logic [1:0] fc,
    input logic [7:0] dv
  );
    exp_t x;
    @(negedge clk);
    rst = r;
    enter = e;
    clear = c;
    digit = d;
    prog = p;
    x.u = u;
    x.l = l;
    x.ec = ec;
    x.fc = fc;
    x.dv = dv;
    x.tag = tag;
    q.push_back(x);
  endtask

  // four digits then the CHECK cycle (enter/clear driven to show they are ignored)
  task automatic code4(
    input logic [15:0] code, input logic [1:0] fc_in,
    input logic [1:0] fc_out, input int res
  );
    logic [3:0] d;
    logic [2:0] n;
    for (int i = 0; i < 4; i++) begin
      d = code[15-4*i -: 4];
      n = 3'(i + 1);
      step(0, 1, 0, d, 0, 0, 0, n, fc_in, {1'b0, n, d});
    end
    if (res == R_OK)
      step(0, 1, 1, 4'h7, 0, 1, 0, 0, 2'd0, 8'h0E);
    else if (res == R_LOCK)
      step(0, 1, 1, 4'h7, 0, 0, 1, 0, fc_out, 8'hFF);
    else
      step(0, 1, 1, 4'h7, 0, 0, 0, 0, fc_out, 8'h00);
  endtask

  task automatic open_run(input int n_high);
    for (int i = 0; i < n_high; i++)
      step(0, 0, 0, 4'h0, 0, 1, 0, 0, 2'd0, 8'h0E);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if (unlocked !== e.u || lockout !== e.l ||
            entry_count !== e.ec || fail_count !== e.fc ||
            display_value !== e.dv) begin
          miscompares++;
          $display("FAIL %s vec%0d: got u=%b l=%b ec=%0d fc=%0d dv=%h, want u=%b l=%b ec=%0d fc=%0d dv=%h",
                   e.tag, vectors, unlocked, lockout, entry_count,
                   fail_count, display_value, e.u, e.l, e.ec,
                   e.fc, e.dv);
        end
      end
    end
  end

  initial begin : stim
    tag = "reset";
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
    step(0, 0, 1, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);

    tag = "unlock";
    code4(16'h1234, 2'd0, 2'd0, R_OK);
    open_run(7);

    tag = "fail_lock";
    code4(16'h1235, 2'd0, 2'd1, R_BAD);
    code4(16'h1235, 2'd1, 2'd2, R_BAD);
    code4(16'h1235, 2'd2, 2'd3, R_LOCK);
    for (int i = 0; i < 15; i++)
      step(0, 1, i[0], 4'h4, 1, 0, 1, 0, 2'd3, 8'hFF);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
    code4(16'h1234, 2'd0, 2'd0, R_OK);
    open_run(7);

    tag = "clear";
    step(0, 1, 0, 4'h1, 0, 0, 0, 3'd1, 2'd0, 8'h11);
    step(0, 1, 0, 4'h2, 0, 0, 0, 3'd2, 2'd0, 8'h22);
    step(0, 1, 1, 4'h3, 0, 0, 0, 3'd0, 2'd0, 8'h00);
    code4(16'h1234, 2'd0, 2'd0, R_OK);
    open_run(7);

    tag = "prog";
    code4(16'h1234, 2'd0, 2'd0, R_OK);
    step(0, 1, 0, 4'hA, 1, 1, 0, 3'd1, 2'd0, 8'h1A);
    step(0, 1, 0, 4'hB, 1, 1, 0, 3'd2, 2'd0, 8'h2B);
    step(0, 1, 0, 4'hC, 1, 1, 0, 3'd3, 2'd0, 8'h3C);
    step(0, 1, 0, 4'hD, 1, 0, 0, 3'd0, 2'd0, 8'h00);
    code4(16'h1234, 2'd0, 2'd1, R_BAD);
    code4(16'hABCD, 2'd1, 2'd0, R_OK);
    open_run(7);

    tag = "prog_abort";
    code4(16'hABCD, 2'd0, 2'd0, R_OK);
    step(0, 0, 0, 4'h0, 0, 1, 0, 3'd0, 2'd0, 8'h0E);
    step(0, 1, 0, 4'h9, 1, 1, 0, 3'd1, 2'd0, 8'h19);
    step(0, 1, 0, 4'h9, 1, 1, 0, 3'd2, 2'd0, 8'h29);
    step(0, 0, 0, 4'h0, 1, 1, 0, 3'd2, 2'd0, 8'h29);
    step(0, 0, 0, 4'h0, 0, 1, 0, 3'd0, 2'd0, 8'h0E);
    open_run(6);
    code4(16'hABCD, 2'd0, 2'd0, R_OK);

    tag = "rst_prog";
    step(0, 1, 0, 4'h5, 1, 1, 0, 3'd1, 2'd0, 8'h15);
    step(1, 1, 0, 4'h6, 1, 0, 0, 3'd0, 2'd0, 8'h00);
    step(0, 0, 0, 4'h0, 0, 0, 0, 3'd0, 2'd0, 8'h00);
    code4(16'hABCD, 2'd0, 2'd1, R_BAD);
    code4(16'h1234, 2'd1, 2'd0, R_OK);
    open_run(7);

    tag = "rst_lock";
    code4(16'h1235, 2'd0, 2'd1, R_BAD);
    code4(16'h1235, 2'd1, 2'd2, R_BAD);
    code4(16'h1235, 2'd2, 2'd3, R_LOCK);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 4'h0, 0, 0, 1, 0, 2'd3, 8'hFF);
    step(1, 1, 0, 4'h1, 1, 0, 0, 0, 2'd0, 8'h00);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 8'h00);
    code4(16'h1234, 2'd0, 2'd0, R_OK);
    open_run(7);

    @(negedge clk);
    rst = 0;
    enter = 0;
    clear = 0;
    prog = 0;
    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
